// File: rtl/product_accumulator_pkg.sv
// rtl/product_accumulator_pkg.sv - shared FSM state, Q8.8 constants and accumulator sizing
package product_accumulator_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    OUTPUT = 2'd2
  } state_t;

  localparam int          Q_FRAC_BITS = 8;
  localparam logic [15:0] Q_MAX       = 16'h7FFF;
  localparam logic [15:0] Q_MIN       = 16'h8000;

  // Enough headroom that summing n full-scale elements can never overflow.
  function automatic int acc_width(input int data_width, input int n);
    return data_width + $clog2(n);
  endfunction

endpackage

// File: rtl/product_accumulator_row_adder.sv
// rtl/product_accumulator_row_adder.sv - combinational sign-extended sum of one kernel row
module row_adder #(
  parameter int DATA_WIDTH  = 16,
  parameter int KERNEL_SIZE = 5,
  parameter int ACC_WIDTH   = 21
) (
  input  logic [KERNEL_SIZE*DATA_WIDTH-1:0] row,
  output logic signed [ACC_WIDTH-1:0]       row_sum
);

  always_comb begin
    row_sum = '0;
    for (int i = 0; i < KERNEL_SIZE; i++) begin
      row_sum = row_sum + ACC_WIDTH'($signed(row[i*DATA_WIDTH +: DATA_WIDTH]));
    end
  end

endmodule

// File: rtl/product_accumulator.sv
// rtl/product_accumulator.sv - row-serial sum of a KERNEL_SIZE**2 Q8.8 product vector
// Narrowing mode selected by PRODUCT_ACCUMULATOR_SATURATE_EN (saturate) or wrap when undefined.
module product_accumulator
  import product_accumulator_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int KERNEL_SIZE = 5,
  parameter int FRAC_BITS   = Q_FRAC_BITS
) (
  input  logic                                        clk,
  input  logic                                        reset_n,
  input  logic [(KERNEL_SIZE*KERNEL_SIZE)*DATA_WIDTH-1:0] products,
  input  logic                                        in_valid,
  output logic                                        in_ready,
  output logic [DATA_WIDTH-1:0]                       sum,
  output logic                                        out_valid,
  input  logic                                        out_ready
);

  localparam int ACC_WIDTH = acc_width(DATA_WIDTH, KERNEL_SIZE * KERNEL_SIZE);
  localparam int ROW_W     = KERNEL_SIZE * DATA_WIDTH;
  localparam int ROW_CW    = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1;
  localparam logic [ROW_CW-1:0] ROW_LAST = ROW_CW'(KERNEL_SIZE - 1);

  localparam logic signed [ACC_WIDTH-1:0] SAT_HI =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_LO =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  // All elements share one binary point, so the fraction width only needs to fit.
  if (FRAC_BITS >= DATA_WIDTH) begin : g_bad_frac
    $error("FRAC_BITS must be smaller than DATA_WIDTH");
  end

  state_t                       state, state_next;
  logic [ROW_W-1:0]             rows [KERNEL_SIZE];
  logic [ROW_CW-1:0]            row_cnt;
  logic signed [ACC_WIDTH-1:0]  acc;
  logic signed [ACC_WIDTH-1:0]  row_sum;
  logic                         accept;

  assign accept = in_valid && in_ready;

  row_adder #(
    .DATA_WIDTH (DATA_WIDTH),
    .KERNEL_SIZE(KERNEL_SIZE),
    .ACC_WIDTH  (ACC_WIDTH)
  ) u_row_adder (
    .row    (rows[row_cnt]),
    .row_sum(row_sum)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = ACCUM;
      ACCUM:   if (row_cnt == ROW_LAST) state_next = OUTPUT;
      OUTPUT:  if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == OUTPUT);
  end

  // The vector is snapshotted at accept so later bus activity cannot leak in.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      acc     <= '0;
      row_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            for (int r = 0; r < KERNEL_SIZE; r++) begin
              rows[r] <= products[r*ROW_W +: ROW_W];
            end
            acc     <= '0;
            row_cnt <= '0;
          end
        end
        ACCUM: begin
          acc     <= acc + row_sum;
          row_cnt <= row_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    sum = acc[DATA_WIDTH-1:0];
`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
    if (acc > SAT_HI)      sum = SAT_HI[DATA_WIDTH-1:0];
    else if (acc < SAT_LO) sum = SAT_LO[DATA_WIDTH-1:0];
`endif
  end

endmodule

// File: tb/tb_product_accumulator.sv
// tb/tb_product_accumulator.sv - scoreboard bench for product_accumulator (both narrowing modes)
module tb_product_accumulator;

  localparam int DW = 16;
  localparam int K  = 5;
  localparam int N  = K * K;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic [N*DW-1:0] products = '0;
  logic            in_valid = 1'b0;
  logic            out_ready = 1'b1;
  logic            in_ready;
  logic [DW-1:0]   sum;
  logic            out_valid;

  int n_checks = 0;
  int n_fail   = 0;
  int n_out    = 0;
  logic [DW-1:0] exp_q[$];

  product_accumulator #(.DATA_WIDTH(DW), .KERNEL_SIZE(K), .FRAC_BITS(8)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .products (products),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .sum      (sum),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready) begin
      logic [DW-1:0] e;
      n_out++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output: got %h expected none", sum);
      end else begin
        e = exp_q.pop_front();
        check("sum", {16'h0, sum}, {16'h0, e});
      end
    end
  end

  function automatic logic [N*DW-1:0] fill(input logic [DW-1:0] a, input int na,
                                           input logic [DW-1:0] b);
    logic [N*DW-1:0] v;
    for (int j = 0; j < N; j++) v[j*DW +: DW] = (j < na) ? a : b;
    return v;
  endfunction

  task automatic wait_ready();
    int c;
    c = 0;
    while (in_ready !== 1'b1 && c < 50) begin
      @(posedge clk); #1;
      c++;
    end
    if (c >= 50) begin
      n_checks++;
      n_fail++;
      $display("FAIL in_ready_timeout: got 0 expected 1 within 50 cycles");
    end
  endtask

  // Returns #1 after the accept edge, with the bus scrambled to prove it was snapshotted.
  task automatic send(input logic [N*DW-1:0] vec, input logic [DW-1:0] exp, input bit push);
    wait_ready();
    products = vec;
    in_valid = 1'b1;
    if (push) exp_q.push_back(exp);
    @(posedge clk); #1;
    in_valid = 1'b0;
    products = {N{16'h5A5A}};
  endtask

  task automatic drain();
    int c;
    c = 0;
    while (exp_q.size() > 0 && c < 50) begin
      @(posedge clk); #1;
      c++;
    end
    if (c >= 50) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
    end
    @(posedge clk); #1;
  endtask

  initial begin
    logic [DW-1:0] s0;
    int c;

    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_in_ready", {31'h0, in_ready}, 32'd1);
    check("reset_out_valid", {31'h0, out_valid}, 32'd0);
    check("reset_sum", {16'h0, sum}, 32'h0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // 25 x 1.0 = 25.0, out_valid exactly 5 cycles after accept
    send(fill(16'h0100, N, 16'h0000), 16'h1900, 1'b1);
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
      if (k == 4) check("latency_not_early", {31'h0, out_valid}, 32'd0);
      if (k == 5) check("latency_on_time", {31'h0, out_valid}, 32'd1);
    end
    drain();

    send(fill(16'h0200, 12, 16'hFE00), 16'hFE00, 1'b1);
    drain();

`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
    send(fill(16'h0600, N, 16'h0000), 16'h7FFF, 1'b1);
    drain();
    send(fill(16'hF000, N, 16'h0000), 16'h8000, 1'b1);
    drain();
`else
    send(fill(16'h0600, N, 16'h0000), 16'h9600, 1'b1);
    drain();
    send(fill(16'hF000, N, 16'h0000), 16'h7000, 1'b1);
    drain();
`endif

    // Backpressure: 3 x 1.0 + 22 x -1.0 = -19.0
    out_ready = 1'b0;
    send(fill(16'h0100, 3, 16'hFF00), 16'hED00, 1'b1);
    c = 0;
    while (out_valid !== 1'b1 && c < 20) begin
      @(posedge clk); #1;
      c++;
    end
    check("stall_reached_output", {31'h0, out_valid}, 32'd1);
    s0 = sum;
    check("stall_sum_value", {16'h0, s0}, 32'h0000ED00);
    products = fill(16'h0100, N, 16'h0000);
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("stall_out_valid", {31'h0, out_valid}, 32'd1);
      check("stall_sum_stable", {16'h0, sum}, {16'h0, s0});
      check("stall_in_ready", {31'h0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("release_in_ready", {31'h0, in_ready}, 32'd1);
    check("release_out_valid", {31'h0, out_valid}, 32'd0);

    // Reset during the 2nd ACCUM cycle discards the vector
    send(fill(16'h0100, N, 16'h0000), 16'h0000, 1'b0);
    @(posedge clk); #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    check("midreset_out_valid", {31'h0, out_valid}, 32'd0);
    check("midreset_sum", {16'h0, sum}, 32'h0);
    check("midreset_in_ready", {31'h0, in_ready}, 32'd1);
    reset_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;

    check("queue_empty", exp_q.size(), 32'd0);
    check("output_count", n_out, 32'd5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
